// File: rtl/pll_reset_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Holds the sequencer state encoding and the counter-width helper.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        RELEASE,
        RUN,
        FAULT
    } state_e;

    // Bits needed to hold any value in 0 .. max_val-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = (max_val <= 1) ? 1 : $clog2(max_val);
        return w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock with timeout/retry,
// then releases per-domain resets in a staged order; any lock loss re-arms everything.
module pll_reset_ctrl
    import pll_reset_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned NUM_DOMAINS         = 4,
    parameter int unsigned STAGE_GAP_CYCLES    = 8
) (
    input  logic                                    refclk_i,
    input  logic                                    rst_i,
    input  logic                                    pll_locked_i,
    input  logic                                    sw_relock_i,
    output logic                                    pll_rst_o,
    output logic [NUM_DOMAINS-1:0]                  domain_rst_req_o,
    output logic                                    all_ready_o,
    output logic                                    fault_o,
    output logic [cnt_width(MAX_RETRIES + 1)-1:0]   retry_count_o
);

    localparam int unsigned CNT_MAX_A =
        (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_MAX =
        (CNT_MAX_A > STAGE_GAP_CYCLES) ? CNT_MAX_A : STAGE_GAP_CYCLES;

    localparam int unsigned CW = cnt_width(CNT_MAX);
    localparam int unsigned SW = cnt_width(LOCK_STABLE_CYCLES);
    localparam int unsigned RW = cnt_width(MAX_RETRIES + 1);
    localparam int unsigned IW = cnt_width(NUM_DOMAINS + 1);

    localparam logic [CW-1:0] PULSE_LAST  = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);
    localparam logic [IW-1:0] STAGE_END   = IW'(NUM_DOMAINS);
    localparam logic [IW-1:0] STAGE_FIRST = IW'(1);

    localparam logic [NUM_DOMAINS-1:0] REQ_ONE   = NUM_DOMAINS'(1);
    localparam logic [NUM_DOMAINS-1:0] REQ_FIRST = ~REQ_ONE;

    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [SW-1:0]          stable_q;
    logic [IW-1:0]          stage_q;
    logic                   pll_rst_q;
    logic [NUM_DOMAINS-1:0] req_q;
    logic                   all_ready_q;
    logic                   fault_q;
    logic [RW-1:0]          retry_q;

    logic                   lk;
    logic [CW-1:0]          cnt_inc;
    logic [SW-1:0]          stable_inc;

    sync_2ff u_lock_sync (
        .clk_i (refclk_i),
        .rst_i (rst_i),
        .d_i   (pll_locked_i),
        .q_o   (lk)
    );

    // Saturating increments for the shared counters.
    always_comb begin
        cnt_inc    = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        stable_inc = (stable_q == {SW{1'b1}}) ? stable_q : stable_q + 1'b1;
    end

    always_ff @(posedge refclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            stable_q    <= '0;
            stage_q     <= '0;
            pll_rst_q   <= 1'b1;
            req_q       <= '1;
            all_ready_q <= 1'b0;
            fault_q     <= 1'b0;
            retry_q     <= '0;
        end else if (sw_relock_i) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            stable_q    <= '0;
            stage_q     <= '0;
            pll_rst_q   <= 1'b1;
            req_q       <= '1;
            all_ready_q <= 1'b0;
            fault_q     <= 1'b0;
            retry_q     <= '0;
        end else begin
            unique case (state_q)
                PLL_RST: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_q   <= WAIT_LOCK;
                        cnt_q     <= '0;
                        stable_q  <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                WAIT_LOCK: begin
                    if (lk && (stable_q == STABLE_LAST)) begin
                        state_q <= RELEASE;
                        cnt_q   <= '0;
                        stage_q <= STAGE_FIRST;
                        req_q   <= REQ_FIRST;
                    end else if (cnt_q == TMO_LAST) begin
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        if (retry_q < RETRY_MAX) begin
                            state_q <= PLL_RST;
                            retry_q <= retry_q + 1'b1;
                        end else begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end
                    end else begin
                        cnt_q    <= cnt_inc;
                        stable_q <= lk ? stable_inc : '0;
                    end
                end
                RELEASE: begin
                    if (!lk) begin
                        state_q     <= PLL_RST;
                        cnt_q       <= '0;
                        pll_rst_q   <= 1'b1;
                        req_q       <= '1;
                        all_ready_q <= 1'b0;
                        retry_q     <= '0;
                    end else if (stage_q == STAGE_END) begin
                        state_q     <= RUN;
                        cnt_q       <= '0;
                        all_ready_q <= 1'b1;
                        retry_q     <= '0;
                    end else if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        stage_q <= stage_q + 1'b1;
                        req_q   <= req_q & ~(REQ_ONE << stage_q);
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state_q     <= PLL_RST;
                        cnt_q       <= '0;
                        pll_rst_q   <= 1'b1;
                        req_q       <= '1;
                        all_ready_q <= 1'b0;
                        retry_q     <= '0;
                    end
                end
                FAULT: begin
                    pll_rst_q <= 1'b1;
                    fault_q   <= 1'b1;
                end
                default: begin
                    state_q     <= PLL_RST;
                    cnt_q       <= '0;
                    pll_rst_q   <= 1'b1;
                    req_q       <= '1;
                    all_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst_o        = pll_rst_q;
    assign domain_rst_req_o = req_q;
    assign all_ready_o      = all_ready_q;
    assign fault_o          = fault_q;
    assign retry_count_o    = retry_q;

endmodule
